// File: rtl/mem_stream_reader_pkg.sv
// Shared types and helpers for the memory-to-Avalon-ST frame reader.
package mem_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Address width for a memory of `size` words; never narrower than one bit.
  function automatic int adr_size_f(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/mem_stream_reader.sv
// Reads len words from a combinational-read memory and streams them as one
// Avalon-ST packet (ready latency 0), pulsing done_o when the last beat leaves.
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter  int WORD     = 8,
  parameter  int SIZE     = 256,
  localparam int ADR_SIZE = adr_size_f(SIZE)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                start_i,
  input  logic [ADR_SIZE:0]   len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [ADR_SIZE-1:0] MemAdr_o,
  input  logic [WORD-1:0]     MemData_i,
  output logic [WORD-1:0]     StData_o,
  output logic                StValid_o,
  input  logic                StReady_i,
  output logic                StSop_o,
  output logic                StEop_o
);

  localparam logic [ADR_SIZE:0]   LEN_MAX = (ADR_SIZE+1)'(SIZE);
  localparam logic [ADR_SIZE:0]   LEN_ONE = (ADR_SIZE+1)'(1);
  localparam logic [ADR_SIZE-1:0] IDX_ONE = ADR_SIZE'(1);

  state_t              state_q, state_d;
  logic [ADR_SIZE-1:0] idx_q;
  logic [ADR_SIZE:0]   len_q;
  logic                load;
  logic                accept;
  logic                last_idx;
  logic                start_frame;
  logic                start_empty;

  assign accept      = StValid_o && StReady_i;
  assign last_idx    = ({1'b0, idx_q} == (len_q - LEN_ONE));
  assign start_frame = (state_q == ST_IDLE) && start_i && (len_i != '0);
  assign start_empty = (state_q == ST_IDLE) && start_i && (len_i == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: each always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_frame)      state_d = ST_RUN;
      ST_RUN:   if (load && last_idx) state_d = ST_DRAIN;
      ST_DRAIN: if (accept)           state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    busy_o   = 1'b0;
    MemAdr_o = '0;
    case (state_q)
      ST_RUN: begin
        busy_o   = 1'b1;
        MemAdr_o = idx_q;
        load     = !StValid_o || StReady_i;
      end
      ST_DRAIN: busy_o = 1'b1;
      default: ;
    endcase
  end

  // Output register: a load refills the beat in the same cycle it is accepted,
  // so a held-high ready gives one beat per cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idx_q     <= '0;
      len_q     <= '0;
      StData_o  <= '0;
      StValid_o <= 1'b0;
      StSop_o   <= 1'b0;
      StEop_o   <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= start_empty || ((state_q == ST_DRAIN) && accept);

      if (start_frame) begin
        len_q <= (len_i > LEN_MAX) ? LEN_MAX : len_i;
        idx_q <= '0;
      end

      if (load) begin
        StData_o  <= MemData_i;
        StValid_o <= 1'b1;
        StSop_o   <= (idx_q == '0);
        StEop_o   <= last_idx;
        if (!last_idx) idx_q <= idx_q + IDX_ONE;
      end else if (accept) begin
        StValid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomized bench for mem_stream_reader: a queue of expected addresses per
// frame drives the expected valid/data/sop/eop/done/busy on every cycle.
module tb_mem_stream_reader;
  import mem_stream_reader_pkg::*;

  localparam int WORD = 8;
  localparam int SIZE = 256;
  localparam int ADR  = adr_size_f(SIZE);

  logic            clk_i = 1'b0;
  logic            rstn_i = 1'b0;
  logic            start_i = 1'b0;
  logic [ADR:0]    len_i = '0;
  logic            busy_o, done_o;
  logic [ADR-1:0]  MemAdr_o;
  logic [WORD-1:0] MemData_i;
  logic [WORD-1:0] StData_o;
  logic            StValid_o;
  logic            StReady_i = 1'b0;
  logic            StSop_o, StEop_o;

  logic [WORD-1:0] mem [SIZE];
  int n_checks = 0;
  int n_fail   = 0;

  assign MemData_i = mem[MemAdr_o];

  always #5 clk_i = ~clk_i;

  mem_stream_reader #(.WORD(WORD), .SIZE(SIZE)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .start_i   (start_i),
    .len_i     (len_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .MemAdr_o  (MemAdr_o),
    .MemData_i (MemData_i),
    .StData_o  (StData_o),
    .StValid_o (StValid_o),
    .StReady_i (StReady_i),
    .StSop_o   (StSop_o),
    .StEop_o   (StEop_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < SIZE; i++) mem[i] = WORD'(16 + i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < SIZE; i++) mem[i] = WORD'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, StValid_o, 0);
    check({tag, "_sop"},   StSop_o,   0);
    check({tag, "_eop"},   StEop_o,   0);
    check({tag, "_done"},  done_o,    0);
    check({tag, "_busy"},  busy_o,    0);
    check({tag, "_data"},  StData_o,  0);
    check({tag, "_adr"},   MemAdr_o,  0);
  endtask

  // Issues start_i in the current cycle (cycle 0) and follows the frame to one
  // cycle past done_o. The model: beats for addresses 0..L-1 appear from cycle 2,
  // each accepted beat is replaced next cycle, done_o follows the last accept.
  task automatic run_frame(input int len_in, input int ready_pct, input int stall_first,
                           input bit mid_start, input int abort_after);
    int q[$];
    int L, fin, stalled, accepted, end_cyc, budget;
    bit rdy, valid_exp, done_exp, busy_exp;
    L        = (len_in > SIZE) ? SIZE : len_in;
    fin      = -1;
    stalled  = 0;
    accepted = 0;
    budget   = 4 * SIZE + 100;
    for (int i = 0; i < L; i++) q.push_back(i);
    start_i   = 1'b1;
    len_i     = (ADR+1)'(len_in);
    StReady_i = 1'b0;
    for (int cyc = 1; ; cyc++) begin
      @(posedge clk_i); #1;
      start_i = mid_start && (cyc == 3);
      if (mid_start) len_i = (ADR+1)'(3);
      valid_exp = (L > 0) && (cyc >= 2) && (q.size() > 0);
      done_exp  = (L == 0) ? (cyc == 1) : (cyc == fin);
      busy_exp  = (L > 0) && (fin < 0 || cyc < fin);
      check("valid", StValid_o, valid_exp);
      check("done",  done_o,    done_exp);
      check("busy",  busy_o,    busy_exp);
      if (valid_exp) begin
        check("data", StData_o, mem[q[0]]);
        check("sop",  StSop_o,  q[0] == 0);
        check("eop",  StEop_o,  q[0] == L - 1);
      end
      if (!busy_exp) check("adr_idle", MemAdr_o, 0);
      rdy = ($urandom_range(0, 99) < ready_pct);
      if (valid_exp && stalled < stall_first) begin
        rdy = 1'b0;
        stalled++;
      end
      StReady_i = rdy;
      if (valid_exp && rdy) begin
        void'(q.pop_front());
        accepted++;
        if (q.size() == 0) fin = cyc + 1;
      end
      if (abort_after > 0 && accepted == abort_after) return;
      end_cyc = (L == 0) ? 2 : ((fin < 0) ? -1 : fin + 1);
      if (cyc == end_cyc) break;
      if (cyc >= budget) begin
        check("frame_timeout_beats_left", 32'(q.size()), 0);
        break;
      end
    end
    start_i = 1'b0;
  endtask

  initial begin
    int len, pct;

    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    fill_pattern();
    run_frame(4, 100, 0, 1'b0, 0);          // nominal frame, full throughput
    run_frame(3, 100, 3, 1'b0, 0);          // first beat back-pressured 3 cycles
    run_frame(1, 100, 0, 1'b0, 0);          // single beat with sop and eop
    run_frame(0, 100, 0, 1'b0, 0);          // empty frame: done only
    run_frame(SIZE + 5, 100, 0, 1'b0, 0);   // clamped to SIZE
    run_frame(SIZE, 70, 0, 1'b0, 0);
    run_frame(6, 100, 0, 1'b1, 0);          // start_i mid-frame is ignored

    // Reset in the middle of an 8-word frame, then a clean 2-word frame.
    run_frame(8, 100, 0, 1'b0, 2);
    #2 rstn_i = 1'b0;
    #1 check_all_zero("midreset");
    @(posedge clk_i); #1;
    check_all_zero("inreset");
    rstn_i    = 1'b1;
    StReady_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      check("postreset_valid", StValid_o, 0);
      check("postreset_done",  done_o,    0);
    end
    run_frame(2, 100, 0, 1'b0, 0);

    fill_random();
    for (int n = 0; n < 30; n++) begin
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, SIZE + 40) : $urandom_range(0, 20);
      pct = $urandom_range(30, 100);
      run_frame(len, pct, $urandom_range(0, 2), 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
